muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised, multi-cycle successor to the single-cycle ALU: an iterative multiply/divide engine that owns the HI/LO register pair.
- Sits beside the execute-stage ALU. The pipeline issues an op through a valid/ready handshake, stalls on busy, and reads hi/lo directly.
- Provides signed/unsigned multiply and divide, plus MTHI/MTLO writes and abort on pipeline flush.

Parameters:
WIDTH, 32, operand and HI/LO width in bits; legal range >= 4.
CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
start_valid  in  1  op request
start_ready  out  1  unit can accept an op; high only in IDLE
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved
a  in  WIDTH  operand 1 (dividend / multiplicand / MTHI-MTLO data)
b  in  WIDTH  operand 2 (divisor / multiplier)
flush  in  1  abort the in-flight op
busy  out  1  high in RUN and FIX
done  out  1  one-cycle pulse when a MULT/DIV result commits to hi/lo
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, done=0, busy=0, start_ready=1, counter=0. Reset overrides every other input and aborts any op in flight.
- Accept: start_valid & start_ready & ~flush. Operands and op are latched on the accept edge; the inputs are don't-care afterwards.
- MTHI/MTLO: on the accept edge, write a into hi or lo. State stays IDLE, no done pulse, and back-to-back accepts are allowed.
- Reserved op: accepted, no effect, state stays IDLE.
- MULT/MULTU/DIV/DIVU: IDLE -> RUN on accept.
  - Signed ops take operand magnitudes and record the result signs.
  - RUN iterates WIDTH cycles, one bit per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - RUN -> FIX after the WIDTH-th iteration. FIX applies sign correction.
  - FIX -> IDLE, writing hi/lo and asserting done on that edge.
- Latency: accept in cycle 0; done=1 and new hi/lo visible in cycle WIDTH+2 (cycle 34 for WIDTH=32). During that done cycle the unit is in IDLE with start_ready=1, so an op accepted then gives back-to-back issue.
- Multiply result: {hi,lo} = full 2*WIDTH-bit product, signed or unsigned.
- Divide result: lo = quotient truncated toward zero, hi = remainder, with the remainder taking the sign of the dividend.
- Divide by zero, signed or unsigned: lo = all ones, hi = a. No exception is raised.
- Signed overflow (a = MIN_INT, b = -1): lo = MIN_INT, hi = 0.
- hi/lo hold their values while busy. They change only on a commit edge, an MTHI/MTLO accept, or reset.
- flush:
  - In RUN/FIX: next state is IDLE, hi/lo are left unchanged, and no done pulse follows.
  - In IDLE: flush blocks the accept and leaves hi/lo unchanged.
  - flush and start_valid in the same cycle: flush wins.
  - flush asserted in the FIX cycle: the commit is suppressed.
- start_valid while busy is ignored (start_ready=0). The requester holds its op.
- The counter must not wrap. RUN exits exactly when the count reaches WIDTH.

Test Plan:
1. reset; MULT a=0xFFFFFFFE, b=0x00000003 at cycle 0 -> busy cycles 1..33, start_ready=0 over the same cycles; done=1 and busy=0 at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
2. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Issue DIVU in the done cycle; it is accepted there, with no bubble.
3. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=0x00000007.
4. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000. Then DIVU a=100, b=7 -> lo=14, hi=2.
5. MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles -> hi/lo updated on the respective edges, no done pulse, start_ready stays 1. Then DIVU with flush at cycle 10 -> idle at cycle 11, hi/lo still 0x12345678/0x9ABCDEF0, no done ever pulses.
6. Reset at cycle 20 of a MULT -> all outputs return to reset values next cycle and no done pulses. A separate MULT with flush held in its FIX cycle -> commit suppressed.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine owning the HI/LO register pair.
// One result bit per cycle: shift-add multiply, restoring shift-subtract divide.
module muldiv_unit #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return (~v) + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return (~v) + (2*WIDTH)'(1);
    endfunction

    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? neg_w(v) : v;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               accept_s;
    logic               signed_op_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic               div_ge_s;
    logic [WIDTH-1:0]   div_sub_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    assign accept_s    = start_valid && (state_q == S_IDLE) && !flush;
    assign signed_op_s = !op[0];
    assign mag_a_s     = abs_w(a, signed_op_s);
    assign mag_b_s     = abs_w(b, signed_op_s);
    assign cnt_inc_s   = cnt_q + CNT_W'(1);

    // The carry out of the add shifts down into the upper product half.
    assign mul_sum_s   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign div_shift_s = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_ge_s    = div_shift_s >= {1'b0, opnd_q};
    assign div_sub_s   = div_shift_s[WIDTH-1:0] - opnd_q;

    assign prod_s = neg_res_q ? neg_2w({acc_hi_q, acc_lo_q}) : {acc_hi_q, acc_lo_q};
    assign quo_s  = div0_q ? {WIDTH{1'b1}} : (neg_res_q ? neg_w(acc_lo_q) : acc_lo_q);
    assign rem_s  = neg_rem_q ? neg_w(acc_hi_q) : acc_hi_q;

    // Next-state, datapath iteration and HI/LO commit selection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        opnd_d    = opnd_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            opnd_d    = mag_a_s;
                            acc_lo_d  = mag_b_s;
                            acc_hi_d  = {WIDTH{1'b0}};
                            neg_res_d = signed_op_s && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_rem_d = 1'b0;
                            div0_d    = 1'b0;
                            is_div_d  = 1'b0;
                            cnt_d     = {CNT_W{1'b0}};
                            state_d   = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            opnd_d    = mag_b_s;
                            acc_lo_d  = mag_a_s;
                            acc_hi_d  = {WIDTH{1'b0}};
                            neg_res_d = signed_op_s && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_rem_d = signed_op_s && a[WIDTH-1];
                            div0_d    = (b == {WIDTH{1'b0}});
                            is_div_d  = 1'b1;
                            cnt_d     = {CNT_W{1'b0}};
                            state_d   = S_RUN;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    if (is_div_q) begin
                        if (div_ge_s) begin
                            acc_hi_d = div_sub_s;
                            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi_d = div_shift_s[WIDTH-1:0];
                            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi_d = mul_sum_s[WIDTH:1];
                        acc_lo_d = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s == CNT_W'(WIDTH)) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                cnt_d   = {CNT_W{1'b0}};
                if (flush) begin
                    done_d = 1'b0;
                end else begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_s;
                        lo_d = quo_s;
                    end else begin
                        hi_d = prod_s[2*WIDTH-1:WIDTH];
                        lo_d = prod_s[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            opnd_q    <= {WIDTH{1'b0}};
            acc_hi_q  <= {WIDTH{1'b0}};
            acc_lo_q  <= {WIDTH{1'b0}};
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            opnd_q    <= opnd_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign start_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes reference {hi,lo} results,
// a negedge monitor pops and compares them whenever done pulses.
module tb_muldiv_unit;

    localparam int W = 32;
    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3;
    localparam logic [2:0] MTHI = 3'd4, MTLO = 3'd5, RSVD = 3'd6;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_valid;
    logic         start_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb[$];

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
        .op(op), .a(a), .b(b), .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: returns {hi,lo} from plain arithmetic on the operation's definition.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        longint unsigned ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            MULT:  return sx * sy;
            MULTU: return ux * uy;
            DIV: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            DIVU: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = longint'(ux / uy);
                r = longint'(ux % uy);
                return {r[31:0], q[31:0]};
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom());
        endcase
    endfunction

    // Drives one request for the next rising edge; waits (bounded) for start_ready.
    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        int n = 0;
        while (!start_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!start_ready) check("issue_ready_timeout", {63'd0, start_ready}, 64'd1);
        start_valid = 1'b1;
        op = o;
        a = av;
        b = bv;
        if (o <= DIVU) sb.push_back(model(o, av, bv));
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        a = $urandom();
        b = $urandom();
        op = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {63'd0, done}, 64'd1);
    endtask

    task automatic watch_no_done(input string name, input int cycles);
        int cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check(name, 64'(cnt), 64'd0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        logic [63:0] e;
        if (!reset && done) begin
            check("sb_pending", {63'd0, sb.size() != 0}, 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_hi", {32'd0, hi}, {32'd0, e[63:32]});
                check("sb_lo", {32'd0, lo}, {32'd0, e[31:0]});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] busy_m, rdy_m, done_m;
        logic [31:0] av, bv;
        logic [2:0]  ro;
        busy_m = 64'd0;
        rdy_m  = 64'd0;
        done_m = 64'd0;
        reset = 1'b1;
        start_valid = 1'b0;
        flush = 1'b0;
        op = 3'd0;
        a = 32'd0;
        b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_ready", {63'd0, start_ready}, 64'd1);
        check("rst_done", {63'd0, done}, 64'd0);

        // Test 1: latency profile of a signed multiply.
        issue(MULT, 32'hFFFF_FFFE, 32'h0000_0003);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            busy_m[k] = busy;
            rdy_m[k]  = start_ready;
            done_m[k] = done;
        end
        check("t1_busy_cycles", busy_m, 64'h0000_0003_FFFF_FFFE);
        check("t1_ready_cycles", rdy_m, 64'h0000_01FC_0000_0000);
        check("t1_done_cycle", done_m, 64'h0000_0004_0000_0000);
        check("t1_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
        check("t1_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFA);

        // Test 2: MULTU then DIVU issued in the done cycle.
        @(negedge clk);
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done();
        check("t2_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
        check("t2_lo", {32'd0, lo}, 64'h0000_0000_0000_0001);
        check("t2_ready_in_done", {63'd0, start_ready}, 64'd1);
        issue(DIVU, 32'd1000, 32'd3);
        @(negedge clk);
        check("t2_b2b_busy", {63'd0, busy}, 64'd1);
        wait_done();
        check("t2_divu_lo", {32'd0, lo}, 64'd333);
        check("t2_divu_hi", {32'd0, hi}, 64'd1);

        // Test 3: signed divide rounding and divide by zero.
        @(negedge clk);
        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done();
        check("t3_div_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
        check("t3_div_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
        issue(DIVU, 32'd7, 32'd0);
        wait_done();
        check("t3_div0_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);
        check("t3_div0_hi", {32'd0, hi}, 64'd7);

        // Test 4: signed overflow and a plain unsigned divide.
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done();
        check("t4_ovf_lo", {32'd0, lo}, 64'h0000_0000_8000_0000);
        check("t4_ovf_hi", {32'd0, hi}, 64'd0);
        issue(DIVU, 32'd100, 32'd7);
        wait_done();
        check("t4_lo", {32'd0, lo}, 64'd14);
        check("t4_hi", {32'd0, hi}, 64'd2);

        // Test 5: MTHI/MTLO back to back, then a flushed DIVU.
        @(negedge clk);
        issue(MTHI, 32'h1234_5678, 32'd0);
        check("t5_mthi", {32'd0, hi}, 64'h0000_0000_1234_5678);
        check("t5_mthi_done", {63'd0, done}, 64'd0);
        issue(MTLO, 32'h9ABC_DEF0, 32'd0);
        check("t5_mtlo", {32'd0, lo}, 64'h0000_0000_9ABC_DEF0);
        check("t5_mtlo_hi", {32'd0, hi}, 64'h0000_0000_1234_5678);
        check("t5_ready", {63'd0, start_ready}, 64'd1);
        check("t5_mtlo_done", {63'd0, done}, 64'd0);
        issue(DIVU, 32'd12345, 32'd17);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        check("t5_flush_idle", {62'd0, busy, start_ready}, 64'd1);
        watch_no_done("t5_flush_no_done", 40);
        check("t5_hold_hi", {32'd0, hi}, 64'h0000_0000_1234_5678);
        check("t5_hold_lo", {32'd0, lo}, 64'h0000_0000_9ABC_DEF0);

        // Flush in IDLE blocks an accept; a reserved op does nothing.
        start_valid = 1'b1;
        op = MTHI;
        a = 32'hDEAD_BEEF;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        flush = 1'b0;
        check("idle_flush_hi", {32'd0, hi}, 64'h0000_0000_1234_5678);
        issue(RSVD, 32'hCAFE_F00D, 32'd5);
        @(negedge clk);
        check("rsvd_state", {62'd0, busy, start_ready}, 64'd1);
        check("rsvd_hi", {32'd0, hi}, 64'h0000_0000_1234_5678);
        check("rsvd_lo", {32'd0, lo}, 64'h0000_0000_9ABC_DEF0);

        // Test 6: reset mid-multiply, then flush in the FIX cycle.
        issue(MULT, 32'h0001_2345, 32'hFFFF_0003);
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        check("t6_rst_hi", {32'd0, hi}, 64'd0);
        check("t6_rst_lo", {32'd0, lo}, 64'd0);
        check("t6_rst_flags", {61'd0, busy, start_ready, done}, 64'd2);
        watch_no_done("t6_rst_no_done", 40);
        issue(MULT, 32'h0000_0055, 32'h0000_0066);
        repeat (32) @(posedge clk);
        #1;
        check("t6_in_fix_busy", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        check("t6_fix_flush_idle", {62'd0, busy, start_ready}, 64'd1);
        watch_no_done("t6_fix_no_done", 10);
        check("t6_fix_hi", {32'd0, hi}, 64'd0);
        check("t6_fix_lo", {32'd0, lo}, 64'd0);

        // Randomized mix, sometimes issuing in the done cycle.
        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 5));
            av = pick();
            bv = pick();
            if ($urandom_range(0, 1) == 0) @(negedge clk);
            issue(ro, av, bv);
            if (ro == MTHI) begin
                check("rnd_mthi", {32'd0, hi}, {32'd0, av});
            end else if (ro == MTLO) begin
                check("rnd_mtlo", {32'd0, lo}, {32'd0, av});
            end else begin
                wait_done();
            end
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
